// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done handshake and operand/result bus of the serial subtractor
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  // Requester side: issues operands and start, observes status and result.
  modport master (
    output start, a, b,
    input  busy, done, diff, borrow
  );

  // Subtractor side.
  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow
  );

endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, one borrow flop
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_subtractor_if.slave bus_if
);

  // Counter sized to hold 0..WIDTH; it never wraps inside one operation.
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q;
  logic             busy_q;
  logic             done_q;
  logic             borrow_q;

  logic             ai;
  logic             bi;
  logic             d_bit;
  logic             br_d;
  logic [WIDTH-1:0] res_d;
  logic             last_bit;

  // One full-subtract slice on the current LSBs, plus the result shift-in.
  always_comb begin
    ai       = sa_q[0];
    bi       = sb_q[0];
    d_bit    = ai ^ bi ^ br_q;
    br_d     = (~ai & bi) | (~(ai ^ bi) & br_q);
    res_d    = {d_bit, res_q[WIDTH-1:1]};
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Control FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          // done is a single-cycle pulse; it drops on any exit from DONE.
          done_q <= 1'b0;
          if (bus_if.start) begin
            sa_q    <= bus_if.a;
            sb_q    <= bus_if.b;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end

        RUN: begin
          // start is deliberately not looked at here: no restart, no queuing.
          sa_q  <= {1'b0, sa_q[WIDTH-1:1]};
          sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
          res_q <= res_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_bit) begin
            // Result is published straight from the shift-in of the final bit.
            diff_q   <= res_d;
            borrow_q <= br_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_if.busy   = busy_q;
  assign bus_if.done   = done_q;
  assign bus_if.diff   = diff_q;
  assign bus_if.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

  localparam int W   = 8;
  localparam int TMO = 40;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [W-1:0] prev_d;
  logic         prev_br;

  serial_subtractor_if #(.WIDTH(W)) bus_if ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain modular subtraction and unsigned compare.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = a - b;
    return r;
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a < b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for exactly one edge; returns at E0+1.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    bus_if.start = 1'b1;
    bus_if.a     = a;
    bus_if.b     = b;
    tick();
    bus_if.start = 1'b0;
  endtask

  // Bounded wait for done; cyc reports edges waited (TMO on timeout).
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (bus_if.done !== 1'b1 && cyc < TMO);
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    #1;
    checks++;
    if ({bus_if.busy, bus_if.done, bus_if.diff, bus_if.borrow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b diff=%h borrow=%b, required all 0",
               bus_if.busy, bus_if.done, bus_if.diff, bus_if.borrow);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", bus_if.busy, bus_if.done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [5];
    logic [W-1:0] vb [5];
    int cyc;
    va = '{8'h5A, 8'h00, 8'h10, 8'hFF, 8'h80};
    vb = '{8'h23, 8'h01, 8'h20, 8'hFF, 8'h00};
    for (int i = 0; i < 5; i++) begin
      launch(va[i], vb[i]);
      checks++;
      if (bus_if.busy !== 1'b1 || bus_if.done !== 1'b0) begin
        errors++;
        $display("FAIL directed_busy[%0d]: busy=%b done=%b, required 1 0", i, bus_if.busy, bus_if.done);
      end
      wait_done(cyc);
      checks++;
      if (cyc !== W) begin
        errors++;
        $display("FAIL directed_latency[%0d]: %0d cycles, required %0d", i, cyc, W);
      end
      checks++;
      if (bus_if.diff !== ref_diff(va[i], vb[i]) || bus_if.borrow !== ref_borrow(va[i], vb[i])
          || bus_if.busy !== 1'b0) begin
        errors++;
        $display("FAIL directed_result[%0d]: diff=%h borrow=%b busy=%b, required diff=%h borrow=%b busy=0",
                 i, bus_if.diff, bus_if.borrow, bus_if.busy, ref_diff(va[i], vb[i]), ref_borrow(va[i], vb[i]));
      end
      tick();
      checks++;
      if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) begin
        errors++;
        $display("FAIL directed_pulse[%0d]: done=%b busy=%b after done cycle, required 0 0",
                 i, bus_if.done, bus_if.busy);
      end
      prev_d  = ref_diff(va[i], vb[i]);
      prev_br = ref_borrow(va[i], vb[i]);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    int cyc;
    int gap;
    for (int i = 0; i < 20; i++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      launch(a, b);
      tick();
      tick();
      checks++;
      if (bus_if.diff !== prev_d || bus_if.borrow !== prev_br || bus_if.busy !== 1'b1) begin
        errors++;
        $display("FAIL random_hold[%0d]: diff=%h borrow=%b busy=%b mid-run, required diff=%h borrow=%b busy=1",
                 i, bus_if.diff, bus_if.borrow, bus_if.busy, prev_d, prev_br);
      end
      wait_done(cyc);
      checks++;
      if (cyc + 2 !== W) begin
        errors++;
        $display("FAIL random_latency[%0d]: %0d cycles, required %0d", i, cyc + 2, W);
      end
      checks++;
      if (bus_if.diff !== ref_diff(a, b) || bus_if.borrow !== ref_borrow(a, b)) begin
        errors++;
        $display("FAIL random_result[%0d]: a=%h b=%h diff=%h borrow=%b, required diff=%h borrow=%b",
                 i, a, b, bus_if.diff, bus_if.borrow, ref_diff(a, b), ref_borrow(a, b));
      end
      prev_d  = ref_diff(a, b);
      prev_br = ref_borrow(a, b);
    end
    tick();
  endtask

  task automatic test_ignore_start();
    int cyc;
    int extra_done;
    int extra_busy;
    launch(8'h5A, 8'h23);
    tick();
    tick();
    bus_if.start = 1'b1;
    bus_if.a     = 8'h01;
    bus_if.b     = 8'h01;
    tick();
    bus_if.start = 1'b0;
    cyc = 3;
    while (bus_if.done !== 1'b1 && cyc < TMO) begin
      bus_if.a = W'($urandom);
      bus_if.b = W'($urandom);
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== W) begin
      errors++;
      $display("FAIL ignore_latency: %0d cycles, required %0d", cyc, W);
    end
    checks++;
    if (bus_if.diff !== 8'h37 || bus_if.borrow !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result: diff=%h borrow=%b, required diff=37 borrow=0", bus_if.diff, bus_if.borrow);
    end
    extra_done = 0;
    extra_busy = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus_if.done === 1'b1) extra_done++;
      if (bus_if.busy === 1'b1) extra_busy++;
    end
    checks++;
    if (extra_done !== 0 || extra_busy !== 0) begin
      errors++;
      $display("FAIL ignore_no_restart: %0d extra done cycles, %0d busy cycles, required 0 0",
               extra_done, extra_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    bus_if.start = 1'b1;
    bus_if.a     = 8'h05;
    bus_if.b     = 8'h03;
    tick();
    for (int k = 1; k <= 3 * (W + 1) - 1; k++) begin
      tick();
      exp_done = ((k % (W + 1)) == W);
      checks++;
      if (bus_if.done !== exp_done || bus_if.busy !== !exp_done) begin
        errors++;
        $display("FAIL b2b_handshake[E%0d]: done=%b busy=%b, required done=%b busy=%b",
                 k, bus_if.done, bus_if.busy, exp_done, !exp_done);
      end
      if (exp_done) begin
        checks++;
        if (bus_if.diff !== 8'h02 || bus_if.borrow !== 1'b0) begin
          errors++;
          $display("FAIL b2b_result[E%0d]: diff=%h borrow=%b, required diff=02 borrow=0",
                   k, bus_if.diff, bus_if.borrow);
        end
      end
    end
    bus_if.start = 1'b0;
    tick();
    checks++;
    if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: done=%b busy=%b, required 0 0", bus_if.done, bus_if.busy);
    end
  endtask

  task automatic test_rst_mid();
    int cyc;
    launch(8'h5A, 8'h23);
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus_if.busy, bus_if.done, bus_if.diff, bus_if.borrow} !== '0) begin
      errors++;
      $display("FAIL rst_mid_async: busy=%b done=%b diff=%h borrow=%b, required all 0",
               bus_if.busy, bus_if.done, bus_if.diff, bus_if.borrow);
    end
    tick();
    tick();
    rst = 1'b0;
    launch(8'h09, 8'h04);
    checks++;
    if (bus_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_restart: busy=%b, required 1", bus_if.busy);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== W || bus_if.diff !== 8'h05 || bus_if.borrow !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_result: %0d cycles diff=%h borrow=%b, required %0d cycles diff=05 borrow=0",
               cyc, bus_if.diff, bus_if.borrow, W);
    end
    tick();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    prev_d  = '0;
    prev_br = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
